// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
//   state_t   : digit-slot FSM states (S_D0 ones, S_D1 tens, S_D2 hundreds)
//   SEG_*     : active-low segment patterns {g,f,e,d,c,b,a}
//   AN_*      : active-low anode patterns, an[0] = rightmost digit
package display_pkg;

  typedef enum logic [1:0] {
    S_D0 = 2'd0,
    S_D1 = 2'd1,
    S_D2 = 2'd2
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic [7:0] AN_D0  = 8'b1111_1110;
  localparam logic [7:0] AN_D1  = 8'b1111_1101;
  localparam logic [7:0] AN_D2  = 8'b1111_1011;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-low outputs.
//   digit : 4-bit BCD value; 10..15 are not BCD and render as a dash
//   seg   : segments {g,f,e,d,c,b,a}, 0 = lit
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Scans a three-digit BCD value onto an 8-digit multiplexed, active-low
// seven-segment display. Digits are snapshotted once per scan frame so the
// shown value never tears; anodes 3..7 stay off.
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high
//   ones/tens/hundreds : live BCD digits from the counter
//   an       : anode enables, active-low, an[0] = rightmost
//   seg      : segments {g,f,e,d,c,b,a}, active-low
//   dp       : decimal point, active-low, always off
//   frame    : one-cycle pulse on the cycle after the snapshot loads
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros on the
// hundreds and tens digits (slot timing is unchanged).
//
// state | meaning
// S_D0  | ones digit on an[0]
// S_D1  | tens digit on an[1]
// S_D2  | hundreds digit on an[2]; snapshot reloads as this slot ends
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  localparam int CNT_W      = $clog2(REFRESH_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  logic [CNT_W-1:0] refresh_cnt;
  logic             tick;
  state_t           state;
  state_t           state_next;
  logic [11:0]      snapshot;
  logic [3:0]       digit;
  logic [6:0]       seg_code;
  logic             blank;
  logic             frame_end;

  assign tick      = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = (state == S_D2) && tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
    end else if (tick) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_D0;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        S_D0:    state_next = S_D1;
        S_D1:    state_next = S_D2;
        default: state_next = S_D0;
      endcase
    end
  end

  // Snapshot loads exactly as the scan wraps back to the ones slot, so all
  // three slots of the following frame show one coherent value.
  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot <= '0;
      frame    <= 1'b0;
    end else begin
      frame <= frame_end;
      if (frame_end) begin
        snapshot <= {hundreds, tens, ones};
      end
    end
  end

  always_comb begin
    digit = snapshot[3:0];
    case (state)
      S_D1:    digit = snapshot[7:4];
      S_D2:    digit = snapshot[11:8];
      default: digit = snapshot[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .digit (digit),
    .seg   (seg_code)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = 1'b0;
    case (state)
      S_D2:    blank = (snapshot[11:8] == 4'd0);
      S_D1:    blank = (snapshot[11:8] == 4'd0) && (snapshot[7:4] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // FSM outputs
  always_comb begin
    an  = AN_D0;
    seg = seg_code;
    case (state)
      S_D1:    an = AN_D1;
      S_D2:    an = AN_D2;
      default: an = AN_D0;
    endcase
    if (blank) begin
      an  = AN_OFF;
      seg = SEG_BLANK;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_display_scanner.sv
module tb_bcd_display_scanner;

  localparam int DIV = 4;

  logic       clk;
  logic       reset;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  int errors = 0;
  int checks = 0;

  bcd_display_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .ones     (ones),
    .tens     (tens),
    .hundreds (hundreds),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are held for n cycles; after each of those rising edges the
  // outputs must match the expected columns.
  typedef struct {
    logic       rst;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    int         n;
    logic [7:0] an;
    logic [6:0] seg;
    logic       frame;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [3:0] h, logic [3:0] t, logic [3:0] o,
                              int n, logic [7:0] an_e, logic [6:0] seg_e, logic frame_e);
    vec_t v;
    v.rst = rst; v.h = h; v.t = t; v.o = o; v.n = n;
    v.an = an_e; v.seg = seg_e; v.frame = frame_e;
    return v;
  endfunction

  task automatic check8(string name, logic [7:0] act, logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_outputs(int row, vec_t v);
    check8($sformatf("an row%0d", row), an, v.an);
    check8($sformatf("seg row%0d", row), {1'b0, seg}, {1'b0, v.seg});
    check8($sformatf("frame row%0d", row), {7'b0, frame}, {7'b0, v.frame});
    check8($sformatf("dp row%0d", row), {7'b0, dp}, 8'd1);
  endtask

  initial begin
    int cyc;
    int period;
    bit seen;

    reset = 1'b1; ones = 4'd0; tens = 4'd0; hundreds = 4'd0;

`ifndef LEADING_ZERO_BLANK_EN
    vecs.push_back(mk(1, 0, 0, 0, 2, 8'hFE, 7'b1000000, 0));
    vecs.push_back(mk(0, 1, 2, 3, 3, 8'hFE, 7'b1000000, 0));
    vecs.push_back(mk(0, 1, 2, 3, 4, 8'hFD, 7'b1000000, 0));
    vecs.push_back(mk(0, 1, 2, 3, 4, 8'hFB, 7'b1000000, 0));
    vecs.push_back(mk(0, 1, 2, 3, 1, 8'hFE, 7'b0110000, 1));
    vecs.push_back(mk(0, 1, 2, 3, 3, 8'hFE, 7'b0110000, 0));
    vecs.push_back(mk(0, 1, 2, 3, 1, 8'hFD, 7'b0100100, 0));
    vecs.push_back(mk(0, 1, 2, 7, 3, 8'hFD, 7'b0100100, 0));
    vecs.push_back(mk(0, 1, 2, 7, 4, 8'hFB, 7'b1111001, 0));
    vecs.push_back(mk(0, 1, 2, 7, 1, 8'hFE, 7'b1111000, 1));
    vecs.push_back(mk(0, 1, 12, 7, 3, 8'hFE, 7'b1111000, 0));
    vecs.push_back(mk(0, 1, 12, 7, 4, 8'hFD, 7'b0100100, 0));
    vecs.push_back(mk(0, 1, 12, 7, 4, 8'hFB, 7'b1111001, 0));
    vecs.push_back(mk(0, 1, 12, 7, 1, 8'hFE, 7'b1111000, 1));
    vecs.push_back(mk(0, 1, 12, 7, 3, 8'hFE, 7'b1111000, 0));
    vecs.push_back(mk(0, 1, 12, 7, 4, 8'hFD, 7'b0111111, 0));
    vecs.push_back(mk(0, 1, 12, 7, 2, 8'hFB, 7'b1111001, 0));
    vecs.push_back(mk(1, 1, 12, 7, 1, 8'hFE, 7'b1000000, 0));
    vecs.push_back(mk(0, 1, 12, 7, 3, 8'hFE, 7'b1000000, 0));
    vecs.push_back(mk(0, 1, 12, 7, 4, 8'hFD, 7'b1000000, 0));
    vecs.push_back(mk(0, 1, 12, 7, 4, 8'hFB, 7'b1000000, 0));
    vecs.push_back(mk(0, 1, 12, 7, 1, 8'hFE, 7'b1111000, 1));
    vecs.push_back(mk(0, 1, 12, 7, 3, 8'hFE, 7'b1111000, 0));
    vecs.push_back(mk(0, 1, 12, 7, 4, 8'hFD, 7'b0111111, 0));
    vecs.push_back(mk(0, 1, 12, 7, 4, 8'hFB, 7'b1111001, 0));
`else
    vecs.push_back(mk(1, 0, 0, 0, 2, 8'hFE, 7'b1000000, 0));
    vecs.push_back(mk(0, 0, 0, 5, 3, 8'hFE, 7'b1000000, 0));
    vecs.push_back(mk(0, 0, 0, 5, 4, 8'hFF, 7'b1111111, 0));
    vecs.push_back(mk(0, 0, 0, 5, 4, 8'hFF, 7'b1111111, 0));
    vecs.push_back(mk(0, 0, 0, 5, 1, 8'hFE, 7'b0010010, 1));
    vecs.push_back(mk(0, 0, 3, 5, 3, 8'hFE, 7'b0010010, 0));
    vecs.push_back(mk(0, 0, 3, 5, 4, 8'hFF, 7'b1111111, 0));
    vecs.push_back(mk(0, 0, 3, 5, 4, 8'hFF, 7'b1111111, 0));
    vecs.push_back(mk(0, 0, 3, 5, 1, 8'hFE, 7'b0010010, 1));
    vecs.push_back(mk(0, 0, 3, 5, 3, 8'hFE, 7'b0010010, 0));
    vecs.push_back(mk(0, 0, 3, 5, 4, 8'hFD, 7'b0110000, 0));
    vecs.push_back(mk(0, 0, 3, 5, 4, 8'hFF, 7'b1111111, 0));
    vecs.push_back(mk(0, 4, 0, 5, 1, 8'hFE, 7'b0010010, 1));
    vecs.push_back(mk(0, 4, 0, 5, 3, 8'hFE, 7'b0010010, 0));
    vecs.push_back(mk(0, 4, 0, 5, 4, 8'hFD, 7'b1000000, 0));
    vecs.push_back(mk(0, 4, 0, 5, 4, 8'hFB, 7'b0011001, 0));
`endif

    @(negedge clk);
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        reset    = vecs[i].rst;
        hundreds = vecs[i].h;
        tens     = vecs[i].t;
        ones     = vecs[i].o;
        @(posedge clk);
        @(negedge clk);
        check_outputs(i, vecs[i]);
      end
    end

    // Frame period: consecutive frame pulses must be exactly 3*DIV apart.
    seen = 0;
    for (cyc = 0; cyc < 4 * DIV; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (frame) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_wait: no frame pulse within %0d cycles", 4 * DIV);
    end else begin
      period = 0;
      seen   = 0;
      for (cyc = 0; cyc < 4 * DIV; cyc++) begin
        @(posedge clk); @(negedge clk);
        period++;
        if (frame) begin seen = 1; break; end
      end
      checks++;
      if (!seen || period != 3 * DIV) begin
        errors++;
        $display("FAIL frame_period: got %0d cycles (seen=%0d) expected %0d", period, seen, 3 * DIV);
      end
      // Right after the frame the ones slot must be lit and the pulse gone.
      @(posedge clk); @(negedge clk);
      check8("frame_after", {7'b0, frame}, 8'd0);
      check8("an_after_frame", an, 8'hFE);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
